// File: rtl/bp_be_scoreboard.sv
// Issue-stage scoreboard: per-register writeback countdown, memory credits,
// fence / single-step / flush control, and the resulting dispatch decision.
module bp_be_scoreboard #(
    parameter int reg_addr_width_p = 5,
    parameter int max_latency_p    = 7,
    parameter int mem_credits_p    = 8,
    localparam int cnt_w           = $clog2(max_latency_p + 1),
    localparam int mem_w           = $clog2(mem_credits_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        isd_v_i,
    input  logic [reg_addr_width_p-1:0] isd_rs1_addr_i,
    input  logic [reg_addr_width_p-1:0] isd_rs2_addr_i,
    input  logic [reg_addr_width_p-1:0] isd_rs3_addr_i,
    input  logic                        isd_rs1_v_i,
    input  logic                        isd_rs2_v_i,
    input  logic                        isd_rs3_v_i,
    input  logic                        isd_rs1_fp_i,
    input  logic                        isd_rs2_fp_i,
    input  logic [reg_addr_width_p-1:0] isd_rd_addr_i,
    input  logic                        isd_rd_v_i,
    input  logic                        isd_rd_fp_i,
    input  logic [cnt_w-1:0]            isd_lat_i,
    input  logic                        isd_mem_v_i,
    input  logic                        isd_fence_v_i,
    input  logic                        mem_ret_i,
    input  logic                        flush_i,
    input  logic                        single_step_i,
    input  logic                        freeze_i,
    output logic                        dispatch_v_o,
    output logic                        data_haz_o,
    output logic                        struct_haz_o,
    output logic                        ctrl_haz_o,
    output logic                        busy_o
);

    localparam int regs_lp = 2 ** reg_addr_width_p;
    localparam logic [mem_w-1:0] mem_full_lp = mem_w'(mem_credits_p);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DRAIN
    } step_state_e;

    logic [regs_lp-1:0][cnt_w-1:0] int_cnt_q, int_cnt_d;
    logic [regs_lp-1:0][cnt_w-1:0] fp_cnt_q, fp_cnt_d;
    logic [regs_lp-1:0]            int_pend, fp_pend;
    logic [mem_w-1:0]              mem_cnt_q, mem_cnt_d;
    step_state_e                   state_q, state_d;

    logic             rs1_haz, rs2_haz, rs3_haz, waw_haz;
    logic [cnt_w-1:0] rd_cnt;
    logic             step_block;
    logic             rd_load;
    logic             mem_inc, mem_dec;

    // A count of 1 means the result is on the bypass this cycle.
    always_comb begin
        int_pend = '0;
        fp_pend  = '0;
        for (int i = 0; i < regs_lp; i++) begin
            int_pend[i] = int_cnt_q[i] > cnt_w'(1);
            fp_pend[i]  = fp_cnt_q[i] > cnt_w'(1);
        end
        int_pend[0] = 1'b0;
    end

    always_comb begin
        rs1_haz = isd_rs1_v_i & (isd_rs1_fp_i ? fp_pend[isd_rs1_addr_i]
                                              : int_pend[isd_rs1_addr_i]);
        rs2_haz = isd_rs2_v_i & (isd_rs2_fp_i ? fp_pend[isd_rs2_addr_i]
                                              : int_pend[isd_rs2_addr_i]);
        rs3_haz = isd_rs3_v_i & fp_pend[isd_rs3_addr_i];
        rd_cnt  = isd_rd_fp_i ? fp_cnt_q[isd_rd_addr_i]
                              : int_cnt_q[isd_rd_addr_i];
        waw_haz = isd_rd_v_i & (rd_cnt > isd_lat_i);

        busy_o       = (|int_cnt_q) | (|fp_cnt_q) | (mem_cnt_q != '0);
        step_block   = (state_q == DRAIN) & busy_o;
        data_haz_o   = rs1_haz | rs2_haz | rs3_haz | waw_haz;
        struct_haz_o = freeze_i | (isd_mem_v_i & (mem_cnt_q == mem_full_lp));
        ctrl_haz_o   = (isd_fence_v_i & busy_o) | step_block | flush_i;
        dispatch_v_o = isd_v_i & ~data_haz_o & ~struct_haz_o & ~ctrl_haz_o;
    end

    always_comb begin
        rd_load = dispatch_v_o & isd_rd_v_i & (isd_lat_i != '0);
        for (int i = 0; i < regs_lp; i++) begin
            int_cnt_d[i] = flush_i ? '0 :
                (int_cnt_q[i] != '0) ? int_cnt_q[i] - cnt_w'(1) : '0;
            fp_cnt_d[i]  = flush_i ? '0 :
                (fp_cnt_q[i] != '0) ? fp_cnt_q[i] - cnt_w'(1) : '0;
        end
        if (rd_load & isd_rd_fp_i) begin
            fp_cnt_d[isd_rd_addr_i] = isd_lat_i;
        end
        if (rd_load & ~isd_rd_fp_i & (isd_rd_addr_i != '0)) begin
            int_cnt_d[isd_rd_addr_i] = isd_lat_i;
        end
    end

    always_comb begin
        mem_inc   = dispatch_v_o & isd_mem_v_i;
        mem_dec   = mem_ret_i & (mem_cnt_q != '0);
        mem_cnt_d = mem_cnt_q;
        if (mem_inc & ~mem_dec) begin
            mem_cnt_d = mem_cnt_q + mem_w'(1);
        end else if (mem_dec & ~mem_inc) begin
            mem_cnt_d = mem_cnt_q - mem_w'(1);
        end
    end

    // Once drained, DRAIN behaves like STEP so the next step issues at once.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, STEP: begin
                if (!single_step_i) state_d = IDLE;
                else if (dispatch_v_o) state_d = DRAIN;
                else state_d = STEP;
            end
            DRAIN: begin
                if (!busy_o) begin
                    if (!single_step_i) state_d = IDLE;
                    else if (dispatch_v_o) state_d = DRAIN;
                    else state_d = STEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            int_cnt_q <= '0;
            fp_cnt_q  <= '0;
            mem_cnt_q <= '0;
            state_q   <= IDLE;
        end else begin
            int_cnt_q <= int_cnt_d;
            fp_cnt_q  <= fp_cnt_d;
            mem_cnt_q <= mem_cnt_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: tb/tb_bp_be_scoreboard.sv
// Directed table plus hand sequences for the issue scoreboard.
module tb_bp_be_scoreboard;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       isd_v_i;
    logic [4:0] rs1_a, rs2_a, rs3_a;
    logic       rs1_v, rs2_v, rs3_v, rs1_fp, rs2_fp;
    logic [4:0] rd_a;
    logic       rd_v, rd_fp;
    logic [2:0] lat;
    logic       mem_v, fence_v, mem_ret, flush, ss, freeze;
    logic       disp, dh, sh, ch, busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bp_be_scoreboard dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .isd_v_i       (isd_v_i),
        .isd_rs1_addr_i(rs1_a),
        .isd_rs2_addr_i(rs2_a),
        .isd_rs3_addr_i(rs3_a),
        .isd_rs1_v_i   (rs1_v),
        .isd_rs2_v_i   (rs2_v),
        .isd_rs3_v_i   (rs3_v),
        .isd_rs1_fp_i  (rs1_fp),
        .isd_rs2_fp_i  (rs2_fp),
        .isd_rd_addr_i (rd_a),
        .isd_rd_v_i    (rd_v),
        .isd_rd_fp_i   (rd_fp),
        .isd_lat_i     (lat),
        .isd_mem_v_i   (mem_v),
        .isd_fence_v_i (fence_v),
        .mem_ret_i     (mem_ret),
        .flush_i       (flush),
        .single_step_i (ss),
        .freeze_i      (freeze),
        .dispatch_v_o  (disp),
        .data_haz_o    (dh),
        .struct_haz_o  (sh),
        .ctrl_haz_o    (ch),
        .busy_o        (busy)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       r1v;
        logic       r1fp;
        logic [4:0] rd;
        logic       rdv;
        logic       rdfp;
        logic [2:0] lat;
        logic [4:0] ctl;  // mem, fence, ret, flush, freeze
        logic [4:0] exp;  // disp, data, struct, ctrl, busy
    } vec_t;

    function automatic vec_t mk(input logic v, input int rs1,
                                input logic r1v, input logic r1fp,
                                input int rd, input logic rdv,
                                input logic rdfp, input int lt,
                                input logic [4:0] ctl,
                                input logic [4:0] exp);
        vec_t t;
        t.v = v; t.rs1 = 5'(rs1); t.r1v = r1v; t.r1fp = r1fp;
        t.rd = 5'(rd); t.rdv = rdv; t.rdfp = rdfp; t.lat = 3'(lt);
        t.ctl = ctl; t.exp = exp;
        return t;
    endfunction

    task automatic clr();
        isd_v_i = 0; rs1_a = 0; rs2_a = 0; rs3_a = 0;
        rs1_v = 0; rs2_v = 0; rs3_v = 0; rs1_fp = 0; rs2_fp = 0;
        rd_a = 0; rd_v = 0; rd_fp = 0; lat = 0;
        mem_v = 0; fence_v = 0; mem_ret = 0; flush = 0; ss = 0; freeze = 0;
    endtask

    task automatic chk(input string nm, input logic [4:0] act,
                       input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {disp,data,struct,ctrl,busy}=%b expected %b",
                     nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic [4:0] exp);
        @(negedge clk);
        chk(nm, {disp, dh, sh, ch, busy}, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        reset_i = 1;
        @(posedge clk);
        #1;
        reset_i = 0;
    endtask

    task automatic op(input int rd, input logic fp, input int lt);
        isd_v_i = 1; rd_a = 5'(rd); rd_v = 1; rd_fp = fp; lat = 3'(lt);
    endtask

    vec_t tbl[34];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
        tbl[1]  = mk(1, 0, 0, 0, 5, 1, 0, 3, 5'b00000, 5'b10000);
        tbl[2]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b01001);
        tbl[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b01001);
        tbl[4]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b10001);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 0, 7, 5'b00000, 5'b10000);
        tbl[6]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b10000);
        tbl[7]  = mk(1, 0, 0, 0, 0, 1, 1, 7, 5'b00000, 5'b10000);
        for (int i = 8; i < 14; i++)
            tbl[i] = mk(1, 0, 1, 1, 0, 0, 0, 0, 5'b00000, 5'b01001);
        tbl[14] = mk(1, 0, 1, 1, 0, 0, 0, 0, 5'b00000, 5'b10001);
        tbl[15] = mk(1, 0, 0, 0, 9, 1, 0, 5, 5'b00000, 5'b10000);
        tbl[16] = mk(1, 0, 0, 0, 9, 1, 0, 2, 5'b00000, 5'b01001);
        tbl[17] = mk(1, 0, 0, 0, 9, 1, 0, 4, 5'b00000, 5'b10001);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00101);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 5'b00011);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
        tbl[21] = mk(1, 9, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b10000);
        tbl[22] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        tbl[23] = mk(1, 0, 0, 0, 3, 1, 0, 4, 5'b00000, 5'b10000);
        for (int i = 24; i < 28; i++)
            tbl[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b00011);
        tbl[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);
        tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 5'b00000);
        tbl[30] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b10000, 5'b10000);
        tbl[31] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b00011);
        tbl[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 5'b00001);
        tbl[33] = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b10000);

        // Reset state and reset-time outputs
        clr();
        reset_i = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_idle", {disp, dh, sh, ch, busy}, 5'b00000);
        isd_v_i = 1; rs1_a = 5; rs1_v = 1; ss = 1;
        #1;
        chk("rst_disp", {disp, dh, sh, ch, busy}, 5'b10000);
        freeze = 1;
        #1;
        chk("rst_freeze", {disp, dh, sh, ch, busy}, 5'b00100);
        freeze = 0; flush = 1;
        #1;
        chk("rst_flush", {disp, dh, sh, ch, busy}, 5'b00010);
        @(posedge clk);
        #1;
        clr();
        reset_i = 0;

        // Table vectors
        for (int i = 0; i < 34; i++) begin
            clr();
            isd_v_i = tbl[i].v;
            rs1_a = tbl[i].rs1; rs1_v = tbl[i].r1v; rs1_fp = tbl[i].r1fp;
            rd_a = tbl[i].rd; rd_v = tbl[i].rdv; rd_fp = tbl[i].rdfp;
            lat = tbl[i].lat;
            {mem_v, fence_v, mem_ret, flush, freeze} = tbl[i].ctl;
            cyc($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // Memory credits
        do_reset();
        for (int i = 0; i < 8; i++) begin
            clr(); isd_v_i = 1; mem_v = 1;
            cyc($sformatf("mem_fill%0d", i), 5'b10001 & {4'b1111, i != 0});
        end
        clr(); isd_v_i = 1; mem_v = 1;
        cyc("mem_full", 5'b00101);
        clr(); isd_v_i = 1;
        cyc("mem_full_nonmem", 5'b10001);
        clr(); isd_v_i = 1; mem_v = 1; mem_ret = 1;
        cyc("mem_ret_same", 5'b00101);
        clr(); isd_v_i = 1; mem_v = 1;
        cyc("mem_after_ret", 5'b10001);
        clr(); isd_v_i = 1; mem_v = 1; mem_ret = 1;
        cyc("mem_full2", 5'b00101);
        clr(); isd_v_i = 1; mem_v = 1; mem_ret = 1;
        cyc("mem_inc_dec", 5'b10001);
        clr(); isd_v_i = 1; mem_v = 1;
        cyc("mem_refill", 5'b10001);
        clr(); isd_v_i = 1; mem_v = 1;
        cyc("mem_full3", 5'b00101);

        // Single-step: one dispatch then drain
        do_reset();
        begin
            logic [4:0] sexp [11];
            sexp[0] = 5'b10000; sexp[1] = 5'b00011; sexp[2] = 5'b00011;
            sexp[3] = 5'b10000; sexp[4] = 5'b00011; sexp[5] = 5'b00011;
            sexp[6] = 5'b10000; sexp[7] = 5'b00011; sexp[8] = 5'b00011;
            sexp[9] = 5'b10000; sexp[10] = 5'b10001;
            for (int i = 0; i < 11; i++) begin
                clr();
                op(10 + i, 0, 2);
                ss = (i < 7);
                cyc($sformatf("step%0d", i), sexp[i]);
            end
        end

        // rs2 / rs3 source checks against fp file
        do_reset();
        op(4, 1, 7);
        cyc("fp_load", 5'b10000);
        clr(); isd_v_i = 1; rs2_a = 4; rs2_v = 1;
        cyc("rs2_int_other_file", 5'b10001);
        clr(); isd_v_i = 1; rs3_a = 4; rs3_v = 1;
        cyc("rs3_fp_pend", 5'b01001);
        clr(); isd_v_i = 1; rs2_a = 4; rs2_v = 1; rs2_fp = 1;
        cyc("rs2_fp_pend", 5'b01001);
        clr(); isd_v_i = 1; rs3_a = 4;
        cyc("rs3_not_read", 5'b10001);

        // Asynchronous reset clears pending state between edges
        do_reset();
        op(7, 0, 7);
        cyc("async_load", 5'b10000);
        clr();
        @(negedge clk);
        chk("async_busy_before", {disp, dh, sh, ch, busy}, 5'b00001);
        #1;
        reset_i = 1;
        #1;
        chk("async_busy_cleared", {disp, dh, sh, ch, busy}, 5'b00000);
        n_chk++;
        if (clk !== 1'b0) begin
            n_fail++;
            $display("FAIL async_no_edge: clk=%b required 0", clk);
        end
        #1;
        reset_i = 0;
        @(negedge clk);
        chk("async_after", {disp, dh, sh, ch, busy}, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
